// File: rtl/fifo_wptr_full.sv
// Write-domain pointer/flag logic of a dual-clock FIFO: binary and Gray write
// pointers, zero-latency full, almost-full, fill level and sticky overflow.
module fifo_wptr_full #(
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned AFULL_THRESH = (2 ** ADDR_WIDTH) - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  ovf_clr,
  input  logic [ADDR_WIDTH:0]   rptr_gray_sync,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow
);

  localparam int unsigned A  = ADDR_WIDTH;
  localparam int unsigned PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AFULL_V = PW'(AFULL_THRESH);

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rbin;
  logic [PW-1:0] level_next;
  logic [PW-1:0] full_cmp;
  logic          push;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      rbin[i] = ^(rptr_gray_sync >> i);
    end
  end

  always_comb begin
    push       = wr_en & ~full;
    wbin_next  = wbin + PW'(push);
    wgray_next = wbin_next ^ (wbin_next >> 1);
    level_next = wbin_next - rbin;
    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    full_cmp   = {~rptr_gray_sync[A:A-1], rptr_gray_sync[A-2:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbin        <= '0;
      wptr_gray   <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      level       <= '0;
      overflow    <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wptr_gray   <= wgray_next;
      full        <= (wgray_next == full_cmp);
      almost_full <= (level_next >= AFULL_V);
      level       <= level_next;
      // Set has priority over clear so a rejected write is never lost.
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  assign waddr = wbin[A-1:0];

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full at ADDR_WIDTH=2, AFULL_THRESH=3.
module tb_fifo_wptr_full;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic       ovf_clr;
  logic [2:0] rptr_gray_sync;
  logic [1:0] waddr;
  logic [2:0] wptr_gray;
  logic       full;
  logic       almost_full;
  logic [2:0] level;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  logic [2:0] wbin_m;
  logic [2:0] rbin_m;
  logic [2:0] level_m;
  logic       full_m;
  logic       push_m;
  logic [2:0] prev_gray;

  fifo_wptr_full #(.ADDR_WIDTH(2), .AFULL_THRESH(3)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .ovf_clr(ovf_clr),
    .rptr_gray_sync(rptr_gray_sync), .waddr(waddr), .wptr_gray(wptr_gray),
    .full(full), .almost_full(almost_full), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] b2g(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] wa, input logic [2:0] wg,
                         input logic fu, input logic af, input logic [2:0] lv,
                         input logic ov);
    chk({tag, ".waddr"}, 32'(waddr), 32'(wa));
    chk({tag, ".wptr_gray"}, 32'(wptr_gray), 32'(wg));
    chk({tag, ".full"}, 32'(full), 32'(fu));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(af));
    chk({tag, ".level"}, 32'(level), 32'(lv));
    chk({tag, ".overflow"}, 32'(overflow), 32'(ov));
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; ovf_clr = 1'b0; rptr_gray_sync = 3'b000;
    step();
    chk_all("reset", 2'd0, 3'b000, 1'b0, 1'b0, 3'd0, 1'b0);

    // 1: fill from empty
    rst = 1'b0; wr_en = 1'b1;
    step(); chk_all("fill1", 2'd1, 3'b001, 1'b0, 1'b0, 3'd1, 1'b0);
    step(); chk_all("fill2", 2'd2, 3'b011, 1'b0, 1'b0, 3'd2, 1'b0);
    step(); chk_all("fill3", 2'd3, 3'b010, 1'b0, 1'b1, 3'd3, 1'b0);
    step(); chk_all("fill4", 2'd0, 3'b110, 1'b1, 1'b1, 3'd4, 1'b0);

    // 2: write while full, clear, then clear+write together
    step(); chk_all("ovf_set", 2'd0, 3'b110, 1'b1, 1'b1, 3'd4, 1'b1);
    wr_en = 1'b0; ovf_clr = 1'b1;
    step(); chk_all("ovf_clr", 2'd0, 3'b110, 1'b1, 1'b1, 3'd4, 1'b0);
    wr_en = 1'b1; ovf_clr = 1'b1;
    step(); chk_all("ovf_setwins", 2'd0, 3'b110, 1'b1, 1'b1, 3'd4, 1'b1);

    // 3: one read frees a slot, one write refills it
    wr_en = 1'b0; ovf_clr = 1'b0; rptr_gray_sync = 3'b001;
    step(); chk_all("read1", 2'd0, 3'b110, 1'b0, 1'b1, 3'd3, 1'b1);
    wr_en = 1'b1;
    step(); chk_all("refill", 2'd1, 3'b111, 1'b1, 1'b1, 3'd4, 1'b1);

    // 4: wrap-around with matched reads and writes, against a model
    wr_en = 1'b0; ovf_clr = 1'b1; rptr_gray_sync = 3'b011;
    step(); chk_all("wrap_pre", 2'd1, 3'b111, 1'b0, 1'b1, 3'd3, 1'b0);
    ovf_clr = 1'b0;
    wbin_m = 3'd5; rbin_m = 3'd2; full_m = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      rbin_m = rbin_m + 3'd1;
      rptr_gray_sync = b2g(rbin_m);
      push_m = wr_en & ~full_m;
      wbin_m = wbin_m + 3'(push_m);
      level_m = wbin_m - rbin_m;
      full_m = (level_m == 3'd4);
      step();
      chk_all("wrap", wbin_m[1:0], b2g(wbin_m), full_m, (level_m >= 3'd3), level_m, 1'b0);
    end

    // 5: reset mid-operation
    wr_en = 1'b0; rst = 1'b1; rptr_gray_sync = 3'b000;
    step(); chk_all("midrst", 2'd0, 3'b000, 1'b0, 1'b0, 3'd0, 1'b0);
    rst = 1'b0; wr_en = 1'b1;
    #1 chk("postrst_waddr", 32'(waddr), 32'd0);
    step(); chk_all("postrst1", 2'd1, 3'b001, 1'b0, 1'b0, 3'd1, 1'b0);

    // 6: random writes with a model-driven reader
    wbin_m = 3'd1; rbin_m = 3'd0; full_m = 1'b0; prev_gray = wptr_gray;
    for (int i = 0; i < 200; i++) begin
      wr_en = 1'($urandom_range(0, 1));
      if ((wbin_m != rbin_m) && ($urandom_range(0, 2) == 0)) rbin_m = rbin_m + 3'd1;
      rptr_gray_sync = b2g(rbin_m);
      push_m = wr_en & ~full_m;
      wbin_m = wbin_m + 3'(push_m);
      level_m = wbin_m - rbin_m;
      full_m = (level_m == 3'd4);
      step();
      chk("rnd.hamming", 32'($countones(prev_gray ^ wptr_gray) <= 1), 32'd1);
      chk("rnd.level_max", 32'(level <= 3'd4), 32'd1);
      chk("rnd.level", 32'(level), 32'(level_m));
      chk("rnd.full", 32'(full), 32'(full_m));
      chk("rnd.wptr_gray", 32'(wptr_gray), 32'(b2g(wbin_m)));
      prev_gray = wptr_gray;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
